// File: rtl/cfg_chain_loader.sv
// Serialises bitstream words LSB-first onto a configuration chain head, counting exactly CHAIN_LEN bits.
// Optional CRC-8 check over the shifted bits is enabled by defining CFG_CRC_EN.
module cfg_chain_loader #(
    parameter int CHAIN_LEN = 20,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count
`ifdef CFG_CRC_EN
    ,
    input  logic [7:0]        crc_expected,
    output logic              crc_err
`endif
);

    localparam int HCW = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] WORD_W_C    = CNT_W'(WORD_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WORD_W-1:0]  hold_reg, hold_next, hold_shifted;
    logic [HCW-1:0]     hold_cnt_reg, hold_cnt_next;
    logic [CNT_W-1:0]   sent_reg, sent_next;
    logic [CNT_W-1:0]   bit_count_reg, bit_count_next;
    logic [CNT_W-1:0]   hold_cnt_ext, remaining;
    logic               head_reg, head_next;
    logic               shift_en_reg, shift_en_next;
    logic               start_load, in_load, accept, shift_now, last_bit;

    // Holding register shifts right so bit 0 is always the next bit to leave.
    generate
        for (genvar gi = 0; gi < WORD_W; gi++) begin : g_hold_shift
            if (gi == WORD_W - 1) begin : g_top
                assign hold_shifted[gi] = 1'b0;
            end else begin : g_mid
                assign hold_shifted[gi] = hold_reg[gi+1];
            end
        end
    endgenerate

    assign in_load      = (state_reg == LOAD);
    assign start_load   = (state_reg != LOAD) && start;
    assign hold_cnt_ext = CNT_W'(hold_cnt_reg);
    // Bits still owed to the chain beyond those already issued or held.
    assign remaining    = CHAIN_LEN_C - sent_reg - hold_cnt_ext;

    assign word_ready = in_load && (hold_cnt_reg <= HCW'(1)) && (remaining != '0);
    assign accept     = word_ready && word_valid && !abort;
    assign shift_now  = in_load && (hold_cnt_reg != '0) && !abort;
    assign last_bit   = in_load && !abort && shift_en_reg &&
                        (bit_count_reg == CHAIN_LEN_C - CNT_W'(1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = LOAD;
            LOAD: begin
                if (abort)         state_next = IDLE;
                else if (last_bit) state_next = DONE;
            end
            DONE: if (start) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        hold_next      = hold_reg;
        hold_cnt_next  = hold_cnt_reg;
        sent_next      = sent_reg;
        bit_count_next = bit_count_reg;
        head_next      = head_reg;
        shift_en_next  = 1'b0;
        if (start_load) begin
            hold_next      = '0;
            hold_cnt_next  = '0;
            sent_next      = '0;
            bit_count_next = '0;
        end else if (in_load) begin
            if (abort) begin
                hold_next     = '0;
                hold_cnt_next = '0;
            end else begin
                if (shift_en_reg) bit_count_next = bit_count_reg + CNT_W'(1);
                if (shift_now) begin
                    head_next     = hold_reg[0];
                    shift_en_next = 1'b1;
                    hold_next     = hold_shifted;
                    hold_cnt_next = hold_cnt_reg - HCW'(1);
                    sent_next     = sent_reg + CNT_W'(1);
                end
                // A new word may land while the last held bit leaves; the final
                // word is trimmed so surplus upper bits are never shifted.
                if (accept) begin
                    hold_next     = word_data;
                    hold_cnt_next = (remaining >= WORD_W_C) ? HCW'(WORD_W) : remaining[HCW-1:0];
                end
            end
        end
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_reg     <= IDLE;
            hold_reg      <= '0;
            hold_cnt_reg  <= '0;
            sent_reg      <= '0;
            bit_count_reg <= '0;
            head_reg      <= 1'b0;
            shift_en_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hold_reg      <= hold_next;
            hold_cnt_reg  <= hold_cnt_next;
            sent_reg      <= sent_next;
            bit_count_reg <= bit_count_next;
            head_reg      <= head_next;
            shift_en_reg  <= shift_en_next;
        end
    end

    assign ccff_head     = head_reg;
    assign ccff_shift_en = shift_en_reg;
    assign busy          = in_load;
    assign done          = (state_reg == DONE);
    assign bit_count     = bit_count_reg;

`ifdef CFG_CRC_EN
    logic [7:0] crc_reg, crc_next, crc_upd;
    logic       crc_err_reg, crc_err_next;

    // MSB-first CRC-8, polynomial 0x07, fed with the bit currently on the chain head.
    assign crc_upd = {crc_reg[6:0], 1'b0} ^ ((crc_reg[7] ^ head_reg) ? 8'h07 : 8'h00);

    always_comb begin
        crc_next     = crc_reg;
        crc_err_next = crc_err_reg;
        if (start_load) begin
            crc_next     = '0;
            crc_err_next = 1'b0;
        end else if (in_load && !abort && shift_en_reg) begin
            crc_next = crc_upd;
            if (last_bit) crc_err_next = (crc_upd != crc_expected);
        end
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            crc_reg     <= '0;
            crc_err_reg <= 1'b0;
        end else begin
            crc_reg     <= crc_next;
            crc_err_reg <= crc_err_next;
        end
    end

    assign crc_err = crc_err_reg;
`endif

endmodule

// File: doc/cfg_chain_loader.md
Name: cfg_chain_loader

Overview:
- Programming-side controller for the routing mux configuration chain. The chain is the scan-chained SRAM bits that drive the `sram` and `sram_inv` selects of the `mux_tree_tapbuf` instances.
- Accepts bitstream words over a valid/ready handshake and serialises them LSB-first onto `ccff_head`, one bit per cycle, with a shift-enable.
- Counts exactly CHAIN_LEN bits, then flags completion.
- Sits between the fabric programming interface and the head of a tile's configuration chain.

Parameters:
- CHAIN_LEN, 20, total configuration bits in the chain (>=1), e.g. 10 size-3 muxes x 2 bits.
- WORD_W, 8, width of an input bitstream word (>=2).
- CNT_W, 16, width of the `bit_count` output; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- prog_clk  in  1  programming clock; all state updates on its rising edge.
- prog_reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load.
- abort  in  1  terminates a load in progress.
- word_data  in  WORD_W  bitstream word; bit 0 is shifted first.
- word_valid  in  1  `word_data` is valid.
- word_ready  out  1  loader accepts `word_data` this cycle.
- ccff_head  out  1  serial data to the chain head.
- ccff_shift_en  out  1  chain advances one position at this clock edge.
- busy  out  1  high while in LOAD.
- done  out  1  sticky; set when CHAIN_LEN bits have been shifted.
- bit_count  out  CNT_W  number of bits shifted in the current or last load.

Behaviour:
- Reset: state IDLE. `word_ready`=0, `ccff_head`=0, `ccff_shift_en`=0, `busy`=0, `done`=0, `bit_count`=0. The holding register and its remaining-bit counter are cleared.
- States:
  - IDLE: `start`=1 -> LOAD. On entry to LOAD: `bit_count`=0, `done`=0, holding register empty.
  - LOAD: shift from the holding register. After the bit with `bit_count` reaching CHAIN_LEN -> DONE. `abort`=1 -> IDLE.
  - DONE: `done`=1 and `busy`=0. `start`=1 -> LOAD, which clears `done`.
- `start` is ignored while in LOAD. `abort` takes priority over `start` and over shifting in the same cycle.
- `word_ready` is combinational, asserted only in LOAD, when both hold:
  - the holding register is empty, or holds exactly 1 unshifted bit; and
  - bits still needed (CHAIN_LEN - `bit_count` - bits held) > 0.
- A word is accepted when `word_valid` and `word_ready` are both high at a clock edge. The holding register loads `word_data` with WORD_W bits remaining.
- Shift timing:
  - `ccff_head` and `ccff_shift_en` are registered.
  - For a word accepted at edge t, bit i appears on `ccff_head` with `ccff_shift_en`=1 during cycle t+1+i.
  - `bit_count` increments on each edge where `ccff_shift_en` was high.
- Back-to-back words with `word_valid` held high shift with no bubble.
- A starved holding register (no valid word) gives `ccff_shift_en`=0 and `ccff_head` holds its last value. The chain does not advance.
- Final partial word: only the first (CHAIN_LEN mod WORD_W) bits are shifted, or WORD_W bits if that remainder is 0. The unused upper bits are discarded, and `ccff_shift_en` drops after the CHAIN_LEN-th bit.
- Bit order: the first bit shifted lands at the chain tail. The bitstream generator supplies bits in reverse chain order.
- `bit_count` never exceeds CHAIN_LEN. It holds its value in DONE and IDLE until the next `start`.
- Abort or `prog_reset` mid-load: `ccff_shift_en`=0 from the next cycle, the holding register is dropped, and the chain contents are left partial and undefined. `done` stays 0.
- A word presented while `word_ready`=0 is neither consumed nor corrupted.

Optional Feature:
- Macro `CFG_CRC_EN`.
- When defined:
  - Extra input `crc_expected[7:0]` and output `crc_err`.
  - A CRC-8 (poly 0x07, init 0x00, MSB-first update per shifted bit) runs over every bit where `ccff_shift_en`=1.
  - On entry to DONE, `crc_err` = (crc != `crc_expected`). `crc_err` is sticky until `start` or `prog_reset`.
  - The CRC state is cleared on `start`.
- When undefined: no extra ports and no CRC logic. Timing is identical in both cases.

Test Plan:
- Reset then idle: assert `prog_reset` 2 cycles -> all outputs 0; `word_valid`=1 with no `start` -> `word_ready` stays 0.
- Nominal load, CHAIN_LEN=20, WORD_W=8:
  - stimulus: `start`, then words 0xA5, 0x3C, 0x0F back-to-back;
  - `ccff_head` sequence is 1,0,1,0,0,1,0,1, then 0,0,1,1,1,1,0,0, then 1,1,1,1;
  - `ccff_shift_en` high 20 consecutive cycles, `done`=1 and `bit_count`=20 one cycle after the last shift;
  - the upper nibble of 0x0F is discarded and `word_ready` never reasserts.
- Starvation: drop `word_valid` for 5 cycles between words -> `ccff_shift_en`=0 for exactly those cycles, `ccff_head` held, final `bit_count`=20.
- Abort: assert `abort` after 7 shifted bits -> IDLE next cycle, `done`=0, `bit_count`=7, no further shift; a new `start` reloads from `bit_count`=0.
- Reset mid-load at bit 12 -> all outputs return to reset values the next cycle.
- `CFG_CRC_EN` (same stimulus as the nominal load):
  - `crc_expected` matching the computed CRC -> `crc_err`=0;
  - `crc_expected` XOR 0x01 -> `crc_err`=1 at DONE, cleared on the next `start`.
